pc_seq: RTL
===========

Name: pc_seq

Overview:
- Parametrised program-counter sequencer for the single-cycle RISC core, the next generation of the existing PC block.
- Computes and registers the next fetch address from sequential, relative-branch, page-jump, register-jump, call and return requests.
- Adds an internal circular return-address stack (RAS), stall hold, and sticky stack-error flags.
- Sits between the decoder/control unit and instruction memory; pc_o drives the instruction-memory address.

Parameters:
- PC_W, 16, PC and address width in bits.
- JMP_W, 11, width of the page-jump label; must satisfy JMP_W < PC_W.
- RAS_DEPTH, 4, number of return-stack entries; must be a power of two, ≥ 2.
- IRQ_VEC, 16'h0008, interrupt vector address (used only with IRQ_EN).

Ports:
- CLK  in  1  clock, rising edge.
- CLR  in  1  asynchronous, active-high reset.
- pc_en  in  1  advance enable; low = stall.
- jmp_flag  in  1  page jump request.
- jmp_label  in  JMP_W  page-jump low bits.
- call_flag  in  1  call request; target is call_tgt, return address is pushed.
- call_tgt  in  PC_W  absolute call target.
- ret_flag  in  1  return request; pops the RAS.
- jr_flag  in  1  register-jump request.
- jr_tgt  in  PC_W  register-jump target.
- br_flag  in  1  relative-branch request.
- br_off  in  PC_W  two's-complement branch offset.
- flag_clr  in  1  synchronous clear of the sticky flags.
- pc_o  out  PC_W  current PC.
- ras_cnt  out  $clog2(RAS_DEPTH+1)  number of valid RAS entries.
- ras_ovf  out  1  sticky: a push occurred while the stack was full.
- ras_unf  out  1  sticky: a pop occurred while the stack was empty.

Behaviour:
- Reset (CLR high, asynchronous): pc_o=0, ras_cnt=0, stack pointer=0, ras_ovf=0, ras_unf=0. Stack entry contents are don't-care.
- Next-PC selection (combinational), define inc = pc_o+1. Priority, highest first:
  - jmp: next = {pc_o[PC_W-1:JMP_W], jmp_label}.
  - call: next = call_tgt; push inc.
  - ret: next = top of stack; pop.
  - jr: next = jr_tgt.
  - br: next = pc_o + br_off + 1.
  - otherwise: next = inc.
- Arithmetic: all adds are modulo 2^PC_W. pc_o at all ones wraps to 0.
- Only the winning request acts. A lower-priority call or ret does not touch the stack.
- Update timing: pc_o <= next on the rising edge when pc_en=1. Single-cycle latency from request to pc_o.
- Stall (pc_en=0): pc_o, the stack, ras_cnt and the flags all hold. Requests are ignored, except flag_clr.
- Push when not full: write to the stack pointer, then pointer+1 and ras_cnt+1.
- Push when full (ras_cnt=RAS_DEPTH): circular overwrite of the oldest entry, pointer+1 (wraps), ras_cnt stays RAS_DEPTH, ras_ovf set.
- Pop when not empty: next = entry[pointer-1], then pointer-1 and ras_cnt-1.
- Pop when empty: next = inc (falls through), pointer and ras_cnt unchanged, ras_unf set.
- The stack pointer wraps modulo RAS_DEPTH.
- Flag priority: setting a flag in the same cycle as flag_clr wins, so the flag ends at 1.
- Reset mid-stall or mid-sequence immediately forces the reset values.

Optional Feature:
- Macro: PC_SEQ_IRQ_EN.
- With the macro defined:
  - Extra ports: irq_req in 1, iret_flag in 1, irq_ack out 1, in_isr out 1.
  - irq_req while in_isr=0 and pc_en=1 takes top priority: epc <= next as otherwise computed (RAS side effects suppressed), pc_o <= IRQ_VEC, in_isr <= 1.
  - irq_ack is a one-cycle pulse registered on that same edge.
  - irq_req is ignored while in_isr=1.
  - iret_flag while in_isr=1 ranks just below irq: pc_o <= epc, in_isr <= 0. iret_flag while in_isr=0 is ignored.
  - Reset: epc=0, in_isr=0, irq_ack=0.
- Without the macro: the extra ports and epc do not exist, and behaviour is exactly as above.

Decomposition:
- Shared package pc_seq_pkg:
  - Next-PC select enum: SEL_INC, SEL_BR, SEL_JR, SEL_RET, SEL_CALL, SEL_JMP, SEL_IRQ, SEL_IRET.
  - Default reset PC constant.
- One sub-module, pc_ras: circular stack with push/pop/full/empty, count, top output and ovf/unf events.
- The priority mux and PC register stay in pc_seq.

Test Plan:
- Reset then 3 cycles with pc_en=1 and no requests: pc_o goes 0→1→2→3. Assert CLR mid-cycle: pc_o goes to 0 with no clock edge.
- Branch at pc_o=5 with br_off=16'hFFFC (-4): pc_o=2. With pc_o=16'h0005 and br_off=3: pc_o=9.
- Page jump from pc_o=16'h1234 with jmp_label=11'h0AB: pc_o=16'h10AB. Asserting jmp, call and ret together also gives jmp; ras_cnt unchanged.
- Call to 16'h0100 from pc_o=7, then ret: pc_o=16'h0100, ras_cnt=1; then pc_o=8, ras_cnt=0.
- RAS_DEPTH=4, five calls from PCs 10..14, then five rets:
  - Returns are 15, 14, 13, 12, then the fall-through inc.
  - ras_ovf=1 after the 5th call; ras_unf=1 after the 5th ret.
  - flag_clr clears both flags.
- pc_en=0 for 3 cycles with call_flag=1: pc_o, ras_cnt and flags are unchanged. With PC_SEQ_IRQ_EN, irq_req at pc_o=20 gives pc_o=8, irq_ack pulse, in_isr=1; a second irq is ignored; iret gives pc_o=21.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the pc_seq program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    SEL_INC,
    SEL_BR,
    SEL_JR,
    SEL_RET,
    SEL_CALL,
    SEL_JMP,
    SEL_IRQ,
    SEL_IRET
  } sel_e;

  localparam int unsigned PC_RST = 0;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and a pop when empty leaves the state unchanged; both cases raise a one-cycle event.
module pc_ras #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         CLR,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [W-1:0]                 i_din,
  output logic [W-1:0]                 o_top,
  output logic [$clog2(DEPTH+1)-1:0]   o_cnt,
  output logic                         o_empty,
  output logic                         o_ovf,
  output logic                         o_unf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;
  logic          w_full;

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_top   = r_mem[r_ptr - PW'(1)];
  assign o_cnt   = r_cnt;
  assign o_ovf   = i_push & w_full;
  assign o_unf   = i_pop & o_empty;

  // Entry contents carry no reset; only pointer and count are meaningful after CLR.
  always_ff @(posedge CLK) begin
    if (i_push) r_mem[r_ptr] <= i_din;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_ptr <= r_ptr + PW'(1);
      if (!w_full) r_cnt <= r_cnt + CW'(1);
    end else if (i_pop && !o_empty) begin
      r_ptr <= r_ptr - PW'(1);
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: priority next-PC mux, PC register, RAS and sticky flags.
// Optional interrupt entry/return is enabled by defining PC_SEQ_IRQ_EN.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned JMP_W     = 11,
  parameter int unsigned RAS_DEPTH = 4
`ifdef PC_SEQ_IRQ_EN
  ,
  parameter logic [PC_W-1:0] IRQ_VEC = 16'h0008
`endif
) (
  input  logic                             CLK,
  input  logic                             CLR,
  input  logic                             pc_en,
  input  logic                             jmp_flag,
  input  logic [JMP_W-1:0]                 jmp_label,
  input  logic                             call_flag,
  input  logic [PC_W-1:0]                  call_tgt,
  input  logic                             ret_flag,
  input  logic                             jr_flag,
  input  logic [PC_W-1:0]                  jr_tgt,
  input  logic                             br_flag,
  input  logic [PC_W-1:0]                  br_off,
  input  logic                             flag_clr,
`ifdef PC_SEQ_IRQ_EN
  input  logic                             irq_req,
  input  logic                             iret_flag,
  output logic                             irq_ack,
  output logic                             in_isr,
`endif
  output logic [PC_W-1:0]                  pc_o,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_cnt,
  output logic                             ras_ovf,
  output logic                             ras_unf
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_inc, w_top, w_next_base, w_next;
  sel_e            w_sel_base, w_sel;
  logic            w_empty, w_push, w_pop, w_ovf_evt, w_unf_evt;
  logic            r_ovf, r_unf;

  assign w_inc = r_pc + PC_W'(1);

  always_comb begin
    w_sel_base = SEL_INC;
    if      (jmp_flag)  w_sel_base = SEL_JMP;
    else if (call_flag) w_sel_base = SEL_CALL;
    else if (ret_flag)  w_sel_base = SEL_RET;
    else if (jr_flag)   w_sel_base = SEL_JR;
    else if (br_flag)   w_sel_base = SEL_BR;
  end

  always_comb begin
    w_next_base = w_inc;
    case (w_sel_base)
      SEL_JMP:  w_next_base = {r_pc[PC_W-1:JMP_W], jmp_label};
      SEL_CALL: w_next_base = call_tgt;
      SEL_RET:  w_next_base = w_empty ? w_inc : w_top;
      SEL_JR:   w_next_base = jr_tgt;
      SEL_BR:   w_next_base = r_pc + br_off + PC_W'(1);
      default:  w_next_base = w_inc;
    endcase
  end

`ifdef PC_SEQ_IRQ_EN
  logic [PC_W-1:0] r_epc;
  logic            r_in_isr, r_irq_ack;

  always_comb begin
    w_sel = w_sel_base;
    if      (irq_req && !r_in_isr)  w_sel = SEL_IRQ;
    else if (iret_flag && r_in_isr) w_sel = SEL_IRET;
  end

  always_comb begin
    w_next = w_next_base;
    if      (w_sel == SEL_IRQ)  w_next = IRQ_VEC;
    else if (w_sel == SEL_IRET) w_next = r_epc;
  end

  // epc captures the address that would have been fetched had the interrupt not fired.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_epc     <= '0;
      r_in_isr  <= 1'b0;
      r_irq_ack <= 1'b0;
    end else begin
      r_irq_ack <= pc_en && (w_sel == SEL_IRQ);
      if (pc_en && w_sel == SEL_IRQ) begin
        r_epc    <= w_next_base;
        r_in_isr <= 1'b1;
      end else if (pc_en && w_sel == SEL_IRET) begin
        r_in_isr <= 1'b0;
      end
    end
  end

  assign irq_ack = r_irq_ack;
  assign in_isr  = r_in_isr;
`else
  assign w_sel  = w_sel_base;
  assign w_next = w_next_base;
`endif

  assign w_push = pc_en && (w_sel == SEL_CALL);
  assign w_pop  = pc_en && (w_sel == SEL_RET);

  pc_ras #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK     (CLK),
    .CLR     (CLR),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_inc),
    .o_top   (w_top),
    .o_cnt   (ras_cnt),
    .o_empty (w_empty),
    .o_ovf   (w_ovf_evt),
    .o_unf   (w_unf_evt)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_pc <= PC_W'(PC_RST);
    end else if (pc_en) begin
      r_pc <= w_next;
    end
  end

  // A new event outranks flag_clr in the same cycle.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_evt | (r_ovf & ~flag_clr);
      r_unf <= w_unf_evt | (r_unf & ~flag_clr);
    end
  end

  assign pc_o    = r_pc;
  assign ras_ovf = r_ovf;
  assign ras_unf = r_unf;

endmodule
